// File: rtl/spi_cmd_sequencer.sv
// spi_cmd_sequencer: decodes SPI command words into burst writes, fills and
// control-register updates, and shares the memory write port with game logic.
// Game logic always wins the port. SPI writes go through a 1-entry pending buffer.
// Optional macro SPI_CMD_CHECKSUM_EN adds an XOR checksum of the accepted words.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | after reset, no transaction seen yet
// HDR       | waiting for the header word
// DATA      | WRITE burst, each received word goes into the pending buffer
// FILL_WAIT | FILL, waiting for the fill word
// FILL_RUN  | FILL, loads the fill word once per cycle until rem runs out
// DISCARD   | transaction finished or ignored; waits for the next start
module spi_cmd_sequencer #(
    parameter int          ADDR_W     = 6,
    parameter logic [7:0]  CTRL_RESET = 8'h00
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              start_transaction,
    input  logic              write_en,
    input  logic [15:0]       write_value,
    input  logic              game_req,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [15:0]       game_wdata,
    output logic              game_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [7:0]        ctrl_reg,
    output logic              busy,
    output logic              overflow
`ifdef SPI_CMD_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    typedef enum logic [2:0] {
        IDLE, HDR, DATA, FILL_WAIT, FILL_RUN, DISCARD
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        rem;
    logic [15:0]       fill_word;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
    logic [15:0]       pend_data;

    logic [1:0]        hdr_cmd;
    logic [ADDR_W-1:0] hdr_addr;
    logic [7:0]        hdr_cnt;
    logic              can_load;
    logic              data_acc;
    logic              fill_lat;

    assign hdr_cmd  = write_value[15:14];
    assign hdr_addr = write_value[8 +: ADDR_W];
    assign hdr_cnt  = write_value[7:0];

    // The buffer accepts a new entry when it is empty or drains this cycle
    assign can_load = !pend_valid || !game_req;
    assign data_acc = !start_transaction && (state == DATA) && write_en && can_load;
    assign fill_lat = !start_transaction && (state == FILL_WAIT) && write_en;

    assign busy = ((state != IDLE) && (state != DISCARD)) || pend_valid;

    // Port arbitration, command sequencing and pending-buffer management
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state      <= IDLE;
            addr       <= '0;
            rem        <= '0;
            fill_word  <= '0;
            pend_valid <= 1'b0;
            pend_addr  <= '0;
            pend_data  <= '0;
            game_gnt   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ctrl_reg   <= CTRL_RESET;
            overflow   <= 1'b0;
        end else begin
            game_gnt <= game_req;
            if (game_req) begin
                mem_we    <= 1'b1;
                mem_addr  <= game_addr;
                mem_wdata <= game_wdata;
            end else if (pend_valid) begin
                mem_we     <= 1'b1;
                mem_addr   <= pend_addr;
                mem_wdata  <= pend_data;
                pend_valid <= 1'b0;
            end else begin
                mem_we <= 1'b0;
            end

            // A new transaction restarts decoding; an already pending entry still drains
            if (start_transaction) begin
                state <= HDR;
                addr  <= '0;
                rem   <= '0;
            end else begin
                case (state)
                    HDR: begin
                        if (write_en) begin
                            case (hdr_cmd)
                                2'b00: state <= DISCARD;
                                2'b11: begin
                                    ctrl_reg <= hdr_cnt;
                                    state    <= DISCARD;
                                end
                                default: begin
                                    if (hdr_cnt == 8'd0) begin
                                        state <= DISCARD;
                                    end else begin
                                        addr  <= hdr_addr;
                                        rem   <= hdr_cnt;
                                        state <= (hdr_cmd == 2'b01) ? DATA : FILL_WAIT;
                                    end
                                end
                            endcase
                        end
                    end
                    DATA: begin
                        if (write_en) begin
                            if (can_load) begin
                                pend_valid <= 1'b1;
                                pend_addr  <= addr;
                                pend_data  <= write_value;
                                addr       <= addr + ADDR_ONE;
                                rem        <= rem - 8'd1;
                                if (rem == 8'd1) state <= DISCARD;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                    FILL_WAIT: begin
                        if (write_en) begin
                            fill_word <= write_value;
                            state     <= FILL_RUN;
                        end
                    end
                    FILL_RUN: begin
                        if (write_en) overflow <= 1'b1;
                        if (can_load) begin
                            pend_valid <= 1'b1;
                            pend_addr  <= addr;
                            pend_data  <= fill_word;
                            addr       <= addr + ADDR_ONE;
                            rem        <= rem - 8'd1;
                            if (rem == 8'd1) state <= DISCARD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_CMD_CHECKSUM_EN
    // XOR of every word accepted into the buffer in DATA and the fill word once
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            checksum <= '0;
        end else if (start_transaction) begin
            checksum <= '0;
        end else if (data_acc || fill_lat) begin
            checksum <= checksum ^ write_value;
        end
    end
`endif

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed testbench for spi_cmd_sequencer; memory writes are captured by a
// monitor and compared against hand-computed address/data sequences.
module tb_spi_cmd_sequencer;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        start_transaction = 1'b0;
    logic        write_en = 1'b0;
    logic [15:0] write_value = '0;
    logic        game_req = 1'b0;
    logic [5:0]  game_addr = '0;
    logic [15:0] game_wdata = '0;
    logic        game_gnt;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [7:0]  ctrl_reg;
    logic        busy;
    logic        overflow;
`ifdef SPI_CMD_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [22:0] wr_q[$];
    int          cyc_q[$];

    spi_cmd_sequencer #(.ADDR_W(6), .CTRL_RESET(8'h5A)) dut (
        .clk(clk), .nRst(nRst),
        .start_transaction(start_transaction),
        .write_en(write_en), .write_value(write_value),
        .game_req(game_req), .game_addr(game_addr), .game_wdata(game_wdata),
        .game_gnt(game_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .ctrl_reg(ctrl_reg), .busy(busy),
        .overflow(overflow)
`ifdef SPI_CMD_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_q.push_back({game_gnt, mem_addr, mem_wdata});
            cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic start_tx();
        start_transaction = 1'b1;
        tick();
        start_transaction = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        write_en    = 1'b1;
        write_value = w;
        tick();
        write_en    = 1'b0;
    endtask

    task automatic clear_q();
        wr_q.delete();
        cyc_q.delete();
    endtask

    task automatic expect_wr(input string tag, input logic gnt, input logic [5:0] a,
                             input logic [15:0] d);
        logic [22:0] e;
        chk({tag, " present"}, 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
            e = wr_q.pop_front();
            void'(cyc_q.pop_front());
            chk(tag, 32'(e), 32'({gnt, a, d}));
        end
    endtask

    initial begin
        idle(2);
        chk("rst ctrl_reg", 32'(ctrl_reg), 32'h5A);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        nRst = 1'b1;
        idle(2);

        // CONTROL command
        clear_q();
        start_tx();
        send_word(16'hC0A5);
        idle(3);
        chk("ctrl value", 32'(ctrl_reg), 32'hA5);
        chk("ctrl no write", 32'(wr_q.size()), 32'd0);

        // reset mid-burst
        start_tx();
        send_word(16'h4503);
        send_word(16'h1111);
        tick();
        nRst = 1'b0;
        #1;
        chk("midrst mem_we", 32'(mem_we), 32'd0);
        chk("midrst mem_addr", 32'(mem_addr), 32'd0);
        chk("midrst mem_wdata", 32'(mem_wdata), 32'd0);
        chk("midrst ctrl", 32'(ctrl_reg), 32'h5A);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst gnt", 32'(game_gnt), 32'd0);
        idle(1);
        nRst = 1'b1;
        idle(1);
        clear_q();
        send_word(16'h2222);
        idle(4);
        chk("idle ignore writes", 32'(wr_q.size()), 32'd0);
        chk("idle ignore ovf", 32'(overflow), 32'd0);
        chk("idle busy", 32'(busy), 32'd0);

        // WRITE burst of 3 spaced words, then an extra word
        clear_q();
        start_tx();
        send_word(16'h4503);
        send_word(16'h1111); idle(16);
        send_word(16'h2222); idle(16);
        send_word(16'h3333); idle(16);
        send_word(16'h4444); idle(4);
        expect_wr("burst w0", 1'b0, 6'h05, 16'h1111);
        expect_wr("burst w1", 1'b0, 6'h06, 16'h2222);
        expect_wr("burst w2", 1'b0, 6'h07, 16'h3333);
        chk("burst extra", 32'(wr_q.size()), 32'd0);
        chk("burst ovf", 32'(overflow), 32'd0);
        chk("burst busy", 32'(busy), 32'd0);
`ifdef SPI_CMD_CHECKSUM_EN
        chk("burst checksum", 32'(checksum), 32'h0000);
`endif

        // address wrap
        clear_q();
        start_tx();
        send_word(16'h7F02);
        send_word(16'hAAAA);
        send_word(16'hBBBB);
        idle(4);
        expect_wr("wrap w0", 1'b0, 6'h3F, 16'hAAAA);
        expect_wr("wrap w1", 1'b0, 6'h00, 16'hBBBB);
        chk("wrap extra", 32'(wr_q.size()), 32'd0);

        // back-to-back words, checksum pattern
        clear_q();
        start_tx();
        send_word(16'h4102);
        send_word(16'h1234);
        send_word(16'h00FF);
        idle(4);
        expect_wr("b2b w0", 1'b0, 6'h01, 16'h1234);
        expect_wr("b2b w1", 1'b0, 6'h02, 16'h00FF);
`ifdef SPI_CMD_CHECKSUM_EN
        chk("b2b checksum", 32'(checksum), 32'h12CB);
`endif

        // WRITE with zero count
        clear_q();
        start_tx();
        send_word(16'h4000);
        send_word(16'h1234);
        idle(4);
        chk("zero cnt writes", 32'(wr_q.size()), 32'd0);
        chk("zero cnt ovf", 32'(overflow), 32'd0);

        // FILL of 4
        clear_q();
        start_tx();
        send_word(16'h8004);
        send_word(16'h00FF);
        idle(8);
        chk("fill count", 32'(wr_q.size()), 32'd4);
        if (cyc_q.size() == 4)
            chk("fill consecutive", 32'(cyc_q[3] - cyc_q[0]), 32'd3);
        for (int i = 0; i < 4; i++)
            expect_wr($sformatf("fill w%0d", i), 1'b0, 6'(i), 16'h00FF);

        // FILL aborted by a new start after three loads
        clear_q();
        start_tx();
        send_word(16'h8808);
        send_word(16'h00FF);
        idle(3);
        start_tx();
        idle(6);
        chk("abort count", 32'(wr_q.size()), 32'd3);
        expect_wr("abort w0", 1'b0, 6'h08, 16'h00FF);
        expect_wr("abort w1", 1'b0, 6'h09, 16'h00FF);
        expect_wr("abort w2", 1'b0, 6'h0A, 16'h00FF);

        // game holds the port for 10 cycles during a burst
        clear_q();
        start_tx();
        send_word(16'h4A02);
        chk("pre game ovf", 32'(overflow), 32'd0);
        game_addr  = 6'h30;
        game_wdata = 16'hBEEF;
        game_req   = 1'b1;
        send_word(16'h5151);
        send_word(16'h6262);
        idle(8);
        game_req = 1'b0;
        idle(4);
        chk("game count", 32'(wr_q.size()), 32'd11);
        for (int i = 0; i < 10; i++)
            expect_wr($sformatf("game w%0d", i), 1'b1, 6'h30, 16'hBEEF);
        expect_wr("game held spi", 1'b0, 6'h0A, 16'h5151);
        chk("game ovf", 32'(overflow), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_cmd_sequencer.md
Name: spi_cmd_sequencer

Overview:
- Sits between the SPI slave interface and the game's shared register/brick memory write port.
- Decodes the 16-bit words the SPI slave delivers per transaction into header and data phases, and sequences burst writes, fill operations and control-register updates.
- Arbitrates the single memory write port between game logic, which has priority, and SPI-originated writes held in a 1-entry pending buffer.

Parameters:
- ADDR_W, 6, memory address width; addresses wrap modulo 2^ADDR_W.
- CTRL_RESET, 8'h00, reset value of ctrl_reg.

Ports:
- clk  input  1  system clock.
- nRst  input  1  reset, asynchronous, active-low.
- start_transaction  input  1  1-cycle pulse at SPI select assertion.
- write_en  input  1  1-cycle pulse: write_value holds a complete received word.
- write_value  input  16  received SPI word.
- game_req  input  1  game logic requests the write port.
- game_addr  input  ADDR_W  game write address.
- game_wdata  input  16  game write data.
- game_gnt  output  1  game owns the port this cycle.
- mem_we  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory write address.
- mem_wdata  output  16  memory write data.
- ctrl_reg  output  8  control byte written by the CONTROL command.
- busy  output  1  FSM not in IDLE/DISCARD, or pending buffer valid.
- overflow  output  1  sticky: SPI word dropped.

Behaviour:
- Reset values: ctrl_reg=CTRL_RESET. All other outputs 0. FSM=IDLE, pending buffer empty.
- Header word format: [15:14] cmd (00 NOP, 01 WRITE, 10 FILL, 11 CONTROL), [13:8] start address (low ADDR_W bits used), [7:0] count / control byte.
- FSM states: IDLE, HDR, DATA, FILL_WAIT, FILL_RUN, DISCARD.
- start_transaction in any state -> HDR, and clears the address and remaining registers. A valid pending entry is not flushed and still completes. FILL_RUN is aborted immediately.
- HDR, on write_en:
  - NOP -> DISCARD.
  - CONTROL -> ctrl_reg<=write_value[7:0] on the next edge, -> DISCARD.
  - WRITE or FILL with count==0 -> DISCARD, no writes.
  - WRITE -> DATA; FILL -> FILL_WAIT; addr<=start, rem<=count.
- DATA, on write_en:
  - If the pending buffer is empty, or drains in this same cycle: load the buffer {addr, word}, addr<=addr+1, rem<=rem-1.
  - Otherwise set overflow, drop the word, leave addr and rem unchanged.
  - rem reaching 0 -> DISCARD.
- FILL_WAIT, on write_en: latch the fill word -> FILL_RUN.
- FILL_RUN:
  - Each cycle the pending buffer is empty, load {addr, fill word}, addr++, rem--.
  - rem==0 after load -> DISCARD.
  - write_en received in FILL_RUN sets overflow and is dropped.
- DISCARD: write_en ignored, no overflow. Leaves only on start_transaction.
- IDLE: write_en ignored. IDLE is entered only from reset.
- Arbitration, registered outputs, 1-cycle latency:
  - game_req=1 -> next cycle mem_we=1 with the game address/data, game_gnt=1.
  - Otherwise, if pending is valid -> mem_we=1 with the pending contents, and pending clears.
  - Game writes are never stalled. SPI writes wait indefinitely while game_req is held.
- Simultaneous pending drain and new load in the same cycle is allowed (back-to-back throughput of 1/cycle).
- Address increment wraps: 2^ADDR_W-1 -> 0.
- overflow clears only on reset.

Optional Feature:
- Macro: SPI_CMD_CHECKSUM_EN.
- When defined:
  - Adds output port checksum (16 bits), reset 0.
  - checksum is cleared at start_transaction.
  - checksum XOR-accumulates every data word accepted into the pending buffer in DATA, and the fill word once in FILL_WAIT.
  - Dropped words are excluded.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset mid-burst (nRst low in DATA) -> all outputs 0, ctrl_reg=CTRL_RESET, next write_en without start is ignored.
- start, header 16'h4503, words 1111/2222/3333 spaced 16 cycles, game_req=0 -> mem writes 05:1111, 06:2222, 07:3333; a 4th word produces no write and no overflow.
- start, header 16'h7F02 (addr 63), words AAAA, BBBB -> writes 3F:AAAA then 00:BBBB (wrap).
- game_req held 10 cycles during a WRITE burst with 2 words 1 cycle apart -> game writes every cycle; first SPI word held then written after release; second word sets overflow and is dropped.
- start, header 16'h8004, word 00FF, game_req=0 -> 4 consecutive cycles of writes 00..03 = 00FF; new start mid-fill aborts the remaining writes.
- start, header 16'hC0A5 -> ctrl_reg=A5 and no mem_we. With SPI_CMD_CHECKSUM_EN, the 16'h4503 burst yields checksum 1111^2222^3333=0000, and words 1234/00FF yield 12CB.
